// File: rtl/screen_pkg.sv
// Screen geometry and drawing-engine FSM encoding.
// Holds the per-resolution screen size, helpers that derive coordinate and
// colour widths, and the state encoding that later blitters also use.
package screen_pkg;

    localparam int XMAX_320 = 320;
    localparam int YMAX_320 = 240;
    localparam int XMAX_160 = 160;
    localparam int YMAX_160 = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    function automatic int xmax_of(input bit low_res);
        return low_res ? XMAX_160 : XMAX_320;
    endfunction

    function automatic int ymax_of(input bit low_res);
        return low_res ? YMAX_160 : YMAX_320;
    endfunction

    function automatic int xw_of(input bit low_res);
        return low_res ? 8 : 9;
    endfunction

    function automatic int yw_of(input bit low_res);
        return low_res ? 7 : 8;
    endfunction

    function automatic int cw_of(input int bits_per_channel, input bit mono);
        return mono ? 1 : 3 * bits_per_channel;
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Request and pixel-write bundle between game logic / memory arbiter and the
// rectangle fill engine.
//   req_valid/req_ready   request handshake
//   req_clear             full-screen fill, geometry fields ignored
//   req_x/y/w/h/colour    rectangle geometry and fill colour
//   hold                  arbiter back-pressure
//   x/y/colour/plot       pixel write
//   busy/done             progress status
interface rect_fill_engine_if #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic          req_clear;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic [XW-1:0] req_w;
    logic [YW-1:0] req_h;
    logic [CW-1:0] req_colour;
    logic          hold;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        output req_valid, req_clear, req_x, req_y, req_w, req_h, req_colour, hold,
        input  req_ready, x, y, colour, plot, busy, done
    );

    modport slave (
        input  req_valid, req_clear, req_x, req_y, req_w, req_h, req_colour, hold,
        output req_ready, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a fill request against the screen.
//   clear_i          full-screen region
//   x_i/y_i/w_i/h_i  requested top-left corner and size
//   xs_o/ys_o        first pixel
//   xe_o/ye_o        last column / last row, clipped to the screen
//   empty_o          nothing to draw
module rect_clip #(
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int XMAX = 320,
    parameter int YMAX = 240
) (
    input  logic          clear_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    output logic [XW-1:0] xs_o,
    output logic [YW-1:0] ys_o,
    output logic [XW-1:0] xe_o,
    output logic [YW-1:0] ye_o,
    output logic          empty_o
);
    localparam logic [XW:0]   XMAX_W  = (XW+1)'(XMAX);
    localparam logic [YW:0]   YMAX_W  = (YW+1)'(YMAX);
    localparam logic [XW:0]   XLAST_W = (XW+1)'(XMAX - 1);
    localparam logic [YW:0]   YLAST_W = (YW+1)'(YMAX - 1);
    localparam logic [XW:0]   ONE_X   = (XW+1)'(1);
    localparam logic [YW:0]   ONE_Y   = (YW+1)'(1);

    // One extra bit so x+w-1 cannot wrap before the clip compare.
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;

    assign x_sum = {1'b0, x_i} + {1'b0, w_i} - ONE_X;
    assign y_sum = {1'b0, y_i} + {1'b0, h_i} - ONE_Y;

    always_comb begin
        xs_o    = '0;
        ys_o    = '0;
        xe_o    = XLAST_W[XW-1:0];
        ye_o    = YLAST_W[YW-1:0];
        empty_o = 1'b0;
        if (!clear_i) begin
            xs_o    = x_i;
            ys_o    = y_i;
            xe_o    = (x_sum > XLAST_W) ? XLAST_W[XW-1:0] : x_sum[XW-1:0];
            ye_o    = (y_sum > YLAST_W) ? YLAST_W[YW-1:0] : y_sum[YW-1:0];
            empty_o = (w_i == '0) || (h_i == '0) ||
                      ({1'b0, x_i} >= XMAX_W) || ({1'b0, y_i} >= YMAX_W);
        end
    end
endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle / full-screen fill engine feeding video memory.
// Accepts one request at a time and emits one clipped pixel write per
// non-held cycle in raster order.
//   clock   system clock
//   resetn  synchronous active-low reset
//   bus     request handshake, back-pressure and pixel-write outputs
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_FILL | plot register holds the pending pixel; advances unless held
// ST_DONE | done pulse; an empty request spends one quiet cycle here first
module rect_fill_engine
    import screen_pkg::*;
#(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE"
) (
    input logic clock,
    input logic resetn,
    rect_fill_engine_if.slave bus
);
    localparam bit LOW_RES = (RESOLUTION == "160x120");
    localparam bit MONO    = (MONOCHROME == "TRUE");
    localparam int XMAX    = xmax_of(LOW_RES);
    localparam int YMAX    = ymax_of(LOW_RES);
    localparam int XW      = xw_of(LOW_RES);
    localparam int YW      = yw_of(LOW_RES);
    localparam int CW      = cw_of(BITS_PER_COLOUR_CHANNEL, MONO);

    fill_state_t   state_q, state_d;
    logic [XW-1:0] x_q, x_d, xs_q, xs_d, xe_q, xe_d;
    logic [YW-1:0] y_q, y_d, ye_q, ye_d;
    logic [CW-1:0] col_q, col_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;

    logic [XW-1:0] clip_xs, clip_xe;
    logic [YW-1:0] clip_ys, clip_ye;
    logic          clip_empty;

    rect_clip #(
        .XW   (XW),
        .YW   (YW),
        .XMAX (XMAX),
        .YMAX (YMAX)
    ) u_clip (
        .clear_i (bus.req_clear),
        .x_i     (bus.req_x),
        .y_i     (bus.req_y),
        .w_i     (bus.req_w),
        .h_i     (bus.req_h),
        .xs_o    (clip_xs),
        .ys_o    (clip_ys),
        .xe_o    (clip_xe),
        .ye_o    (clip_ye),
        .empty_o (clip_empty)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        unique case (state_q)
            ST_IDLE: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.req_valid) begin
                    xs_d   = clip_xs;
                    xe_d   = clip_xe;
                    ye_d   = clip_ye;
                    col_d  = bus.req_colour;
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    if (clip_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d     = clip_xs;
                        y_d     = clip_ys;
                        plot_d  = 1'b1;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // plot_q high means the pixel at (x_q,y_q) went out this
                // cycle; low means it is still pending after a hold.
                if (plot_q) begin
                    if (x_q == xe_q && y_q == ye_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        plot_d = !bus.hold;
                        if (x_q == xe_q) begin
                            x_d = xs_q;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end else begin
                    plot_d = !bus.hold;
                end
            end
            ST_DONE: begin
                // Entered from FILL with done already set; an empty request
                // arrives with done clear and raises it one cycle later.
                if (done_q) begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = rdy_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = col_q;
    assign bus.plot      = plot_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    rect_fill_engine_if #(.XW(9), .YW(8), .CW(3)) bus ();

    rect_fill_engine #(
        .RESOLUTION              ("320x240"),
        .BITS_PER_COLOUR_CHANNEL (1),
        .MONOCHROME              ("FALSE")
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit is_done;
        int x;
        int y;
        int col;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endfunction

    function automatic void push_pix(input int px, input int py, input int col);
        exp_t e;
        e.is_done = 1'b0;
        e.x = px;
        e.y = py;
        e.col = col;
        sb.push_back(e);
    endfunction

    function automatic void push_rect(input int x0, input int y0, input int x1,
                                      input int y1, input int col);
        for (int py = y0; py <= y1; py++)
            for (int px = x0; px <= x1; px++)
                push_pix(px, py, col);
    endfunction

    function automatic void push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.x = 0;
        e.y = 0;
        e.col = 0;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: every plot or done pulse consumes one expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (resetn === 1'b1 && (bus.plot === 1'b1 || bus.done === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output plot %0d done %0d x %0d y %0d required nothing",
                         bus.plot, bus.done, bus.x, bus.y);
            end else begin
                e = sb.pop_front();
                chk("out_kind", int'({bus.done, bus.plot}), e.is_done ? 2 : 1);
                if (!e.is_done && bus.plot === 1'b1) begin
                    chk("plot_x", int'(bus.x), e.x);
                    chk("plot_y", int'(bus.y), e.y);
                    chk("plot_colour", int'(bus.colour), e.col);
                    chk("plot_busy", int'(bus.busy), 1);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request; returns at #1 into the first cycle after accept.
    task automatic issue(input bit clr, input int rx, input int ry, input int rw,
                         input int rh, input int col);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_clear  = clr;
        bus.req_x      = 9'(rx);
        bus.req_y      = 8'(ry);
        bus.req_w      = 9'(rw);
        bus.req_h      = 8'(rh);
        bus.req_colour = 3'(col);
        tick();
        bus.req_valid  = 1'b0;
        bus.req_clear  = 1'b0;
        bus.req_x      = 9'd7;
        bus.req_y      = 8'd3;
        bus.req_w      = 9'd9;
        bus.req_h      = 8'd9;
        bus.req_colour = 3'd6;
    endtask

    // k counts edges since the accept edge; exp_lat is the edge count at
    // which done must be seen.
    task automatic wait_done(input string name, input int k_start, input int exp_lat);
        int k;
        int busy_low;
        k = k_start;
        busy_low = 0;
        while (bus.done !== 1'b1 && k < 100000) begin
            if (bus.busy !== 1'b1) busy_low++;
            tick();
            k++;
        end
        chk({name, "_done_latency"}, k, exp_lat);
        chk({name, "_busy_low_cycles"}, busy_low, 0);
        tick();
        chk({name, "_done_one_cycle"}, int'(bus.done), 0);
        chk({name, "_ready_after"}, int'(bus.req_ready), 1);
    endtask

    initial begin
        int n;
        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_clear  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_w      = '0;
        bus.req_h      = '0;
        bus.req_colour = '0;
        bus.hold       = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        resetn = 1'b1;
        tick();

        // 3x2 at (10,20); a second request is waved while busy and must be dropped
        push_rect(10, 20, 12, 21, 5);
        push_done();
        issue(1'b0, 10, 20, 3, 2, 5);
        chk("t1_first_plot", int'(bus.plot), 1);
        bus.req_valid = 1'b1;
        bus.req_x = 9'd0;
        bus.req_y = 8'd0;
        bus.req_w = 9'd2;
        bus.req_h = 8'd2;
        tick();
        tick();
        bus.req_valid = 1'b0;
        wait_done("t1", 3, 7);

        // clipped at the bottom-right corner
        push_pix(318, 238, 7);
        push_pix(319, 238, 7);
        push_pix(318, 239, 7);
        push_pix(319, 239, 7);
        push_done();
        issue(1'b0, 318, 238, 5, 5, 7);
        chk("clip_first_plot", int'(bus.plot), 1);
        wait_done("clip", 1, 5);

        // empty: zero width, then x off screen
        push_done();
        issue(1'b0, 10, 10, 0, 5, 1);
        chk("empty_w_no_plot", int'(bus.plot), 0);
        wait_done("empty_w", 1, 2);
        push_done();
        issue(1'b0, 320, 10, 4, 4, 1);
        chk("empty_x_no_plot", int'(bus.plot), 0);
        wait_done("empty_x", 1, 2);

        // hold for 3 cycles on the second pixel of a 4x1 fill
        push_rect(50, 60, 53, 60, 3);
        push_done();
        issue(1'b0, 50, 60, 4, 1, 3);
        chk("hold_first_plot", int'(bus.plot), 1);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_plot_low", int'(bus.plot), 0);
            chk("hold_x_frozen", int'(bus.x), 51);
        end
        bus.hold = 1'b0;
        wait_done("hold", 4, 8);

        // full-screen clear; geometry fields deliberately junk
        push_rect(0, 0, 319, 239, 0);
        push_done();
        issue(1'b1, 7, 9, 1, 1, 0);
        chk("clear_first_plot", int'(bus.plot), 1);
        wait_done("clear", 1, 76801);

        // reset in the middle of a 50x50 fill
        push_rect(100, 100, 149, 149, 6);
        push_done();
        issue(1'b0, 100, 100, 50, 50, 6);
        chk("mid_first_plot", int'(bus.plot), 1);
        for (int i = 0; i < 19; i++) tick();
        resetn = 1'b0;
        sb.delete();
        tick();
        chk("mid_rst_plot", int'(bus.plot), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_ready", int'(bus.req_ready), 1);
        chk("mid_rst_colour", int'(bus.colour), 0);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.plot === 1'b1) n++;
            tick();
        end
        chk("mid_rst_no_plots", n, 0);
        push_rect(5, 5, 6, 6, 2);
        push_done();
        issue(1'b0, 5, 5, 2, 2, 2);
        chk("post_rst_first_plot", int'(bus.plot), 1);
        wait_done("post_rst", 1, 5);

        tick();
        tick();
        chk("scoreboard_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
